// File: rtl/pipe_skid_reg.sv
// Pipeline stage register carrying an opaque payload, with stall/flush handling and a flush-discard counter.
// Latency: one cycle from accept to out_valid; sustains one transfer per cycle while out_ready is high.
// Backpressure: SKID=1 takes in_ready from registered state only; SKID=0 passes out_ready through to in_ready.
module pipe_skid_reg #(
   parameter int                DATA_W  = 32,
   parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
   parameter int                SKID    = 1,
   parameter int                CNT_W   = 16
) (
   input  logic              cpu_clk_50M,
   input  logic              cpu_rst_n,
   input  logic              flush,
   input  logic              stall,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occ,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [DATA_W-1:0] main_dat, main_dat_nxt;
   logic [DATA_W-1:0] skid_dat, skid_dat_nxt;
   logic              main_vld, main_vld_nxt;
   logic              skid_vld, skid_vld_nxt;
   logic [CNT_W-1:0]  flush_cnt_nxt;
   logic              enq;
   logic              deq;

   generate
      if (SKID != 0) begin : g_skid
         assign in_ready = ~skid_vld & ~stall;
      end else begin : g_single
         assign in_ready = (~main_vld | out_ready) & ~stall;
      end
   endgenerate

   // Stall masks both handshakes, so no enqueue or dequeue can happen while frozen.
   assign out_valid = main_vld & ~stall;
   assign out_data  = main_dat;
   assign occ       = {1'b0, main_vld} + {1'b0, skid_vld};
   assign enq       = in_valid & in_ready;
   assign deq       = out_valid & out_ready;

   always_comb begin
      main_dat_nxt  = main_dat;
      main_vld_nxt  = main_vld;
      skid_dat_nxt  = skid_dat;
      skid_vld_nxt  = skid_vld;
      flush_cnt_nxt = flush_cnt;
      if (flush) begin
         main_dat_nxt = NOP_VAL;
         main_vld_nxt = 1'b0;
         skid_dat_nxt = NOP_VAL;
         skid_vld_nxt = 1'b0;
         if ((main_vld | skid_vld) && (flush_cnt != CNT_MAX))
            flush_cnt_nxt = flush_cnt + CNT_W'(1);
      end else if (SKID != 0) begin
         case ({main_vld, skid_vld})
            2'b00: begin
               if (enq) begin
                  main_dat_nxt = in_data;
                  main_vld_nxt = 1'b1;
               end
            end
            2'b10: begin
               if (enq && deq) begin
                  main_dat_nxt = in_data;
               end else if (enq) begin
                  skid_dat_nxt = in_data;
                  skid_vld_nxt = 1'b1;
               end else if (deq) begin
                  main_dat_nxt = NOP_VAL;
                  main_vld_nxt = 1'b0;
               end
            end
            2'b11: begin
               // Skid entry is always the younger one, so it moves up into main.
               if (deq) begin
                  main_dat_nxt = skid_dat;
                  skid_dat_nxt = NOP_VAL;
                  skid_vld_nxt = 1'b0;
               end
            end
            default: begin
               main_dat_nxt = main_dat;
            end
         endcase
      end else begin
         if (enq) begin
            main_dat_nxt = in_data;
            main_vld_nxt = 1'b1;
         end else if (deq) begin
            main_dat_nxt = NOP_VAL;
            main_vld_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         main_dat  <= NOP_VAL;
         main_vld  <= 1'b0;
         skid_dat  <= NOP_VAL;
         skid_vld  <= 1'b0;
         flush_cnt <= '0;
      end else begin
         main_dat  <= main_dat_nxt;
         main_vld  <= main_vld_nxt;
         skid_dat  <= skid_dat_nxt;
         skid_vld  <= skid_vld_nxt;
         flush_cnt <= flush_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Drives a skid instance (SKID=1) and a single-register instance (SKID=0, CNT_W=2) with shared stimulus,
// each compared every cycle against a queue-based reference model.
module tb_pipe_skid_reg;

   localparam logic [31:0] NOP_A = 32'h0000_0000;
   localparam logic [31:0] NOP_B = 32'h0BAD_F00D;

   logic        cpu_clk_50M = 1'b0;
   logic        cpu_rst_n;
   logic        flush, stall, in_valid, out_ready;
   logic [31:0] in_data;

   logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
   logic [31:0] out_data_a, out_data_b;
   logic [1:0]  occ_a, occ_b;
   logic [15:0] flush_cnt_a;
   logic [1:0]  flush_cnt_b;

   int errors = 0;
   int checks = 0;

   logic [31:0] qa[$];
   logic [31:0] qb[$];
   int          cnt_a = 0;
   int          cnt_b = 0;

   always #5 cpu_clk_50M = ~cpu_clk_50M;

   pipe_skid_reg #(.DATA_W(32), .NOP_VAL(NOP_A), .SKID(1), .CNT_W(16)) dut_a (
      .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
      .occ(occ_a), .flush_cnt(flush_cnt_a));

   pipe_skid_reg #(.DATA_W(32), .NOP_VAL(NOP_B), .SKID(0), .CNT_W(2)) dut_b (
      .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n), .flush(flush), .stall(stall),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
      .occ(occ_b), .flush_cnt(flush_cnt_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reset state as seen from the outside of both instances.
   task automatic chk_reset_state(input string tag);
      chk({tag, "_a_out_valid"}, 32'(out_valid_a), 32'd0);
      chk({tag, "_a_out_data"},  out_data_a,        NOP_A);
      chk({tag, "_a_occ"},       32'(occ_a),        32'd0);
      chk({tag, "_a_flush_cnt"}, 32'(flush_cnt_a),  32'd0);
      chk({tag, "_b_out_valid"}, 32'(out_valid_b), 32'd0);
      chk({tag, "_b_out_data"},  out_data_b,        NOP_B);
      chk({tag, "_b_occ"},       32'(occ_b),        32'd0);
      chk({tag, "_b_flush_cnt"}, 32'(flush_cnt_b),  32'd0);
   endtask

   // One clock cycle: apply inputs at the falling edge, check against the model, then advance the model.
   task automatic step(input logic iv, input logic [31:0] id, input logic ordy,
                       input logic st, input logic fl);
      logic rdy_a, rdy_b, ov_a, ov_b;
      in_valid = iv; in_data = id; out_ready = ordy; stall = st; flush = fl;
      #1;
      rdy_a = (qa.size() < 2) && !st;
      rdy_b = ((qb.size() == 0) || ordy) && !st;
      ov_a  = (qa.size() != 0) && !st;
      ov_b  = (qb.size() != 0) && !st;
      chk("a_in_ready",  32'(in_ready_a),  32'(rdy_a));
      chk("a_out_valid", 32'(out_valid_a), 32'(ov_a));
      chk("a_out_data",  out_data_a,       (qa.size() != 0) ? qa[0] : NOP_A);
      chk("a_occ",       32'(occ_a),       32'(qa.size()));
      chk("a_flush_cnt", 32'(flush_cnt_a), 32'(cnt_a));
      chk("b_in_ready",  32'(in_ready_b),  32'(rdy_b));
      chk("b_out_valid", 32'(out_valid_b), 32'(ov_b));
      chk("b_out_data",  out_data_b,       (qb.size() != 0) ? qb[0] : NOP_B);
      chk("b_occ",       32'(occ_b),       32'(qb.size()));
      chk("b_flush_cnt", 32'(flush_cnt_b), 32'(cnt_b));
      @(posedge cpu_clk_50M);
      if (fl) begin
         if (qa.size() != 0 && cnt_a < 65535) cnt_a++;
         if (qb.size() != 0 && cnt_b < 3) cnt_b++;
         qa.delete();
         qb.delete();
      end else begin
         if (ov_a && ordy) qa.delete(0);
         if (iv && rdy_a)  qa.push_back(id);
         if (ov_b && ordy) qb.delete(0);
         if (iv && rdy_b)  qb.push_back(id);
      end
      @(negedge cpu_clk_50M);
   endtask

   initial begin
      cpu_rst_n = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hDEAD_BEEF;
      out_ready = 1'b0;
      stall     = 1'b0;
      flush     = 1'b0;
      repeat (3) @(negedge cpu_clk_50M);
      #1;
      chk_reset_state("rst");
      chk("rst_a_in_ready", 32'(in_ready_a), 32'd1);
      chk("rst_b_in_ready", 32'(in_ready_b), 32'd1);
      @(negedge cpu_clk_50M);
      cpu_rst_n = 1'b1;

      // First edge after release accepts the payload presented during reset.
      step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      chk("first_accept_a", out_data_a, 32'hDEAD_BEEF);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Back-to-back stream with the sink always ready.
      for (int i = 1; i <= 4; i++) step(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Fill while the sink is blocked, then drain.
      step(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
      chk("full_a_occ", 32'(occ_a), 32'd2);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Flush while full, alongside stall and a new payload; then flush while empty.
      step(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hC, 1'b0, 1'b1, 1'b1);
      chk("flush_a_cnt", 32'(flush_cnt_a), 32'd1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Stall holds a single entry, which then leaves exactly once.
      step(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      // Continuous input with out_ready toggling; probe the ready path within one cycle.
      step(1'b1, 32'h7, 1'b1, 1'b0, 1'b0);
      in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("comb_b_rdy_low",  32'(in_ready_b), 32'd0);
      chk("comb_a_rdy_low",  32'(in_ready_a), 32'(qa.size() < 2));
      out_ready = 1'b1;
      #1;
      chk("comb_b_rdy_high", 32'(in_ready_b), 32'd1);
      chk("comb_a_rdy_high", 32'(in_ready_a), 32'(qa.size() < 2));
      step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h9, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'hA, 1'b1, 1'b0, 1'b0);

      // Repeated non-empty flushes saturate the narrow counter.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 32'(32'h100 + i), 1'b0, 1'b0, 1'b0);
         step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      end
      chk("sat_b_cnt", 32'(flush_cnt_b), 32'd3);

      // Randomised traffic.
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 24) == 0));

      // Reset asserted between clock edges with entries held.
      step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
      step(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
      #2;
      cpu_rst_n = 1'b0;
      #1;
      chk_reset_state("midrst");
      qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
      @(negedge cpu_clk_50M);
      cpu_rst_n = 1'b1;
      step(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline stage register, the successor to the fixed per-stage latch registers between MEM and WB.
- Carries an opaque payload of DATA_W bits. Uses a valid/ready handshake with an optional 2-entry skid buffer.
- Honours the legacy `stall` and `flush` controls.
- Loads NOP_VAL on reset/flush/drain, so downstream logic sees a bubble, never stale data.
- Counts flush-discarded instructions for performance monitoring.

Parameters:
- DATA_W, 32, payload width in bits (concatenated stage fields, e.g. wa/wreg/dreg/pc).
- NOP_VAL, {DATA_W{1'b0}}, payload value held when no valid entry.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational ready.
- CNT_W, 16, width of the flush-discard counter.

Ports:
- cpu_clk_50M  in  1  clock, all state updates on rising edge.
- cpu_rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all held entries; highest priority after reset.
- stall  in  1  freeze: no enqueue, no dequeue, out_valid masked.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage accepts a payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data is a valid instruction.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  DATA_W  head payload; NOP_VAL when no valid entry.
- occ  out  2  number of valid entries (0..2; max 1 when SKID=0).
- flush_cnt  out  CNT_W  saturating count of flushes that discarded ≥1 valid entry.

Behaviour:
- Reset (async, cpu_rst_n=0): main/skid payload = NOP_VAL, both valid bits = 0, occ = 0, flush_cnt = 0. out_valid = 0, out_data = NOP_VAL. in_ready = 1 once reset deasserts and stall = 0.
- Definitions: enq = in_valid & in_ready; deq = out_valid & out_ready; out_valid = main_valid & ~stall.
- Latency: payload accepted on edge N appears on out_data/out_valid after edge N (one cycle). Throughput is 1 per cycle when out_ready = 1.
- SKID=1, in_ready = ~skid_valid & ~stall. It is a function of registered state only, with no out_ready→in_ready path.
- SKID=1 state machine (occ):
  - EMPTY: enq → ONE, main <= in_data.
  - ONE, enq & deq → ONE, main <= in_data.
  - ONE, enq only → FULL, skid <= in_data.
  - ONE, deq only → EMPTY, main <= NOP_VAL.
  - ONE, neither → hold.
  - FULL: in_ready = 0. deq → ONE, main <= skid, skid <= NOP_VAL. No deq → hold.
- SKID=0: in_ready = (~main_valid | out_ready) & ~stall.
  - enq → main <= in_data, valid = 1.
  - deq without enq → main <= NOP_VAL, valid = 0.
  - occ ∈ {0,1}.
- Stall: state fully frozen. in_ready = 0 and out_valid = 0 force enq = deq = 0. out_data still shows the head payload.
- Flush (sync, wins over stall, enq, deq):
  - next state EMPTY; all payloads = NOP_VAL; same-cycle in_data is dropped.
  - in_ready = 1 on the following cycle (if no stall).
  - If occ ≠ 0 in the flush cycle, flush_cnt increments by 1, saturating at 2^CNT_W−1.
  - flush with occ = 0 leaves flush_cnt unchanged.
- Order preserved: skid entry is always younger than main. No duplication, no loss except by flush.
- Reset asserted mid-transfer: immediate return to reset values, irrespective of clock.

Test Plan:
- Reset with in_valid = 1, in_data = 0xDEAD_BEEF → out_valid = 0, out_data = 0, in_ready = 1, occ = 0; first edge after release accepts 0xDEAD_BEEF.
- Stream 1,2,3,4 with out_ready = 1 (SKID=1) → out_data 1,2,3,4 on consecutive cycles, one cycle after each enq; occ stays 1.
- Enq 0xA, 0xB with out_ready = 0 → occ = 2, in_ready = 0, out_data = 0xA. Then out_ready = 1 for 2 cycles → 0xA, 0xB, then occ = 0, out_data = NOP_VAL.
- occ = 2, assert flush together with in_valid = 1 (data 0xC) and stall = 1 → next cycle occ = 0, out_data = NOP_VAL, flush_cnt = 1, 0xC never appears. Flush again while empty → flush_cnt stays 1.
- occ = 1 (0x5), stall = 1 for 3 cycles with out_ready = 1 → out_valid = 0, in_ready = 0, out_data = 0x5 held. Release → 0x5 dequeued exactly once.
- SKID=0, CNT_W=2: out_ready toggles 1,0,1 with continuous input → in_ready follows out_ready combinationally while full. Four non-empty flushes → flush_cnt saturates at 3.
